// File: rtl/ysyx_23060278_encoder.sv
// RV32 instruction encoder: packs decoded fields into 32-bit words, with an
// optional LI pseudo-op expansion enabled by YSYX_23060278_ENCODER_LI_EN.
// Ports:
//   clk, rst (sync, active-high)
//   in_valid/in_ready + in_fmt, in_opcode, in_func3, in_func7,
//   in_rs1, in_rs2, in_rd, in_imm      : request side
//   out_valid/out_ready + out_inst, out_last, out_err : word stream side
module ysyx_23060278_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_func3,
    input  logic [6:0]  in_func7,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_last,
    output logic        out_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT  = 2'd1,
        EMIT2 = 2'd2
    } state_t;

    state_t      state, state_n;
    logic        valid_n, last_n, err_n;
    logic [31:0] inst_n;
    logic [31:0] pend, pend_n;

    logic [31:0] enc_first, enc_second;
    logic        enc_last, enc_err;
    logic        accept, advance;

`ifdef YSYX_23060278_ENCODER_LI_EN
    // Upper part rounded so that the sign-extended ADDI lands on imm.
    logic [19:0] li_hi;
    assign li_hi = in_imm[31:12] + {19'd0, in_imm[11]};
`endif

    always_comb begin
        enc_first  = 32'd0;
        enc_second = 32'd0;
        enc_last   = 1'b1;
        enc_err    = 1'b0;
        case (in_fmt)
            3'd0: enc_first = {in_func7, in_rs2, in_rs1, in_func3,
                               in_rd, in_opcode};
            3'd1: enc_first = {in_imm[11:0], in_rs1, in_func3,
                               in_rd, in_opcode};
            3'd2: enc_first = {in_imm[11:5], in_rs2, in_rs1, in_func3,
                               in_imm[4:0], in_opcode};
            3'd3: enc_first = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                               in_func3, in_imm[4:1], in_imm[11],
                               in_opcode};
            3'd4: enc_first = {in_imm[31:12], in_rd, in_opcode};
            3'd5: enc_first = {in_imm[20], in_imm[10:1], in_imm[11],
                               in_imm[19:12], in_rd, in_opcode};
            3'd6: begin
`ifdef YSYX_23060278_ENCODER_LI_EN
                if (li_hi != 20'd0) begin
                    enc_first  = {li_hi, in_rd, 7'b0110111};
                    enc_second = {in_imm[11:0], in_rd, 3'b000,
                                  in_rd, 7'b0010011};
                    enc_last   = 1'b0;
                end else begin
                    enc_first = {in_imm[11:0], 5'd0, 3'b000,
                                 in_rd, 7'b0010011};
                end
`else
                enc_err = 1'b1;
`endif
            end
            default: enc_err = 1'b1;
        endcase
    end

    // A new request may overlap the hand-off of a final word.
    assign in_ready = !rst &&
                      ((state == IDLE) ||
                       (state == EMIT && out_last && out_ready));
    assign accept   = in_valid && in_ready;
    assign advance  = out_valid && out_ready;

    always_comb begin
        state_n = state;
        valid_n = out_valid;
        inst_n  = out_inst;
        last_n  = out_last;
        err_n   = out_err;
        pend_n  = pend;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = EMIT;
                    valid_n = 1'b1;
                    inst_n  = enc_first;
                    last_n  = enc_last;
                    err_n   = enc_err;
                    pend_n  = enc_second;
                end
            end
            EMIT: begin
                if (advance) begin
                    if (!out_last) begin
                        state_n = EMIT2;
                        inst_n  = pend;
                        last_n  = 1'b1;
                    end else if (accept) begin
                        state_n = EMIT;
                        valid_n = 1'b1;
                        inst_n  = enc_first;
                        last_n  = enc_last;
                        err_n   = enc_err;
                        pend_n  = enc_second;
                    end else begin
                        state_n = IDLE;
                        valid_n = 1'b0;
                    end
                end
            end
            EMIT2: begin
                if (advance) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_inst  <= 32'd0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
            pend      <= 32'd0;
        end else begin
            state     <= state_n;
            out_valid <= valid_n;
            out_inst  <= inst_n;
            out_last  <= last_n;
            out_err   <= err_n;
            pend      <= pend_n;
        end
    end

endmodule
